// File: rtl/aip_host_pkg.sv
// Shared definitions for the AIP host master: op codes, FSM states, default widths.
package aip_host_pkg;

    localparam int DEF_DATAWIDTH      = 32;
    localparam int DEF_ADDRWIDTH      = 5;
    localparam int DEF_READ_LATENCY   = 1;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_START = 2'd2,
        OP_WAIT  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_START    = 3'd4,
        ST_WAIT     = 3'd5,
        ST_RESP     = 3'd6
    } state_e;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return ($clog2(max_val + 1) < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/aip_host_cycle_counter.sv
// Loadable down-counter with terminal-count flag; reused for read latency and WAIT timeout.
module aip_host_cycle_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/aip_host_master.sv
// Initiator for the AIP core bus: one command in, one registered bus operation, one response out.
// Define AIP_HOST_TIMEOUT_EN to bound OP_WAIT by TIMEOUT_CYCLES and report rsp_err_o on expiry.
module aip_host_master
    import aip_host_pkg::*;
#(
    parameter int DATAWIDTH      = DEF_DATAWIDTH,
    parameter int ADDRWIDTH      = DEF_ADDRWIDTH,
    parameter int READ_LATENCY   = DEF_READ_LATENCY,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_op_i,
    input  logic [ADDRWIDTH-1:0] cmd_addr_i,
    input  logic [DATAWIDTH-1:0] cmd_data_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATAWIDTH-1:0] rsp_data_o,
    output logic                 rsp_err_o,
    output logic [ADDRWIDTH-1:0] aip_configAX_o,
    output logic [DATAWIDTH-1:0] aip_dataIn_o,
    output logic                 aip_wrEn_o,
    output logic                 aip_rdEn_o,
    output logic                 aip_start_o,
    input  logic [DATAWIDTH-1:0] aip_dataOut_i,
    input  logic                 aip_int_n_i
);

    if (READ_LATENCY < 1 || READ_LATENCY > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("aip_host_master: READ_LATENCY must be 1..15 and TIMEOUT_CYCLES >= 1");
    end

`ifdef AIP_HOST_TIMEOUT_EN
    localparam int CNT_MAX = (TIMEOUT_CYCLES > READ_LATENCY) ? TIMEOUT_CYCLES : READ_LATENCY;
`else
    localparam int CNT_MAX = READ_LATENCY;
`endif
    localparam int CNT_W = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
`ifdef AIP_HOST_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    state_e               state_q, state_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic [DATAWIDTH-1:0] data_q, data_d;
    logic [DATAWIDTH-1:0] rdata_q, rdata_d;
    logic                 wr_q, wr_d;
    logic                 rd_q, rd_d;
    logic                 start_q, start_d;
`ifdef AIP_HOST_TIMEOUT_EN
    logic                 err_q, err_d;
`endif
    logic                 cnt_load;
    logic [CNT_W-1:0]     cnt_load_val;
    logic                 cnt_dec;
    logic                 cnt_tc;

    aip_host_cycle_counter #(
        .WIDTH(CNT_W)
    ) u_cycle_counter (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (cnt_load),
        .load_val_i(cnt_load_val),
        .dec_i     (cnt_dec),
        .tc_o      (cnt_tc)
    );

    // Strobes are asserted on the accepting edge so they coincide with the first cycle of their state.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        rdata_d      = rdata_q;
        wr_d         = 1'b0;
        rd_d         = 1'b0;
        start_d      = 1'b0;
`ifdef AIP_HOST_TIMEOUT_EN
        err_d        = err_q;
`endif
        cnt_load     = 1'b0;
        cnt_load_val = RD_LOAD;
        cnt_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i;
                    data_d  = cmd_data_i;
                    rdata_d = '0;
`ifdef AIP_HOST_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    case (op_e'(cmd_op_i))
                        OP_WRITE: begin
                            state_d = ST_WR;
                            wr_d    = 1'b1;
                        end
                        OP_READ: begin
                            state_d  = ST_RD_ISSUE;
                            rd_d     = 1'b1;
                            cnt_load = 1'b1;
                        end
                        OP_START: begin
                            state_d = ST_START;
                            start_d = 1'b1;
                        end
                        default: begin
                            state_d = ST_WAIT;
`ifdef AIP_HOST_TIMEOUT_EN
                            cnt_load     = 1'b1;
                            cnt_load_val = TO_LOAD;
`endif
                        end
                    endcase
                end
            end
            ST_WR, ST_START: state_d = ST_RESP;
            ST_RD_ISSUE:     state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (cnt_tc) begin
                    state_d = ST_RESP;
                    rdata_d = aip_dataOut_i;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WAIT: begin
                // An interrupt seen on the terminal-count cycle takes priority over the timeout.
                if (!aip_int_n_i) begin
                    state_d = ST_RESP;
`ifdef AIP_HOST_TIMEOUT_EN
                end else if (cnt_tc) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
`endif
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            start_q <= 1'b0;
`ifdef AIP_HOST_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            start_q <= start_d;
`ifdef AIP_HOST_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    assign cmd_ready_o    = (state_q == ST_IDLE);
    assign rsp_valid_o    = (state_q == ST_RESP);
    assign rsp_data_o     = rdata_q;
`ifdef AIP_HOST_TIMEOUT_EN
    assign rsp_err_o      = err_q;
`else
    assign rsp_err_o      = 1'b0;
`endif
    assign aip_configAX_o = addr_q;
    assign aip_dataIn_o   = data_q;
    assign aip_wrEn_o     = wr_q;
    assign aip_rdEn_o     = rd_q;
    assign aip_start_o    = start_q;

endmodule

// File: tb/tb_aip_host_master.sv
// Bench for aip_host_master: main instance at READ_LATENCY=3, a second at READ_LATENCY=1.
// Expectations come from the command-level timing rules; the WAIT bound depends on AIP_HOST_TIMEOUT_EN.
module tb_aip_host_master;

    localparam int LAT_A = 3;
    localparam int TO_A  = 16;
`ifdef AIP_HOST_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;

    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_addr, aip_configAX;
    logic [31:0] cmd_data, rsp_data, aip_dataIn, aip_dataOut;
    logic        aip_wrEn, aip_rdEn, aip_start, aip_int_n;

    logic        cmd_validB, cmd_readyB, rsp_validB, rsp_readyB, rsp_errB;
    logic [1:0]  cmd_opB;
    logic [4:0]  cmd_addrB, aip_configAXB;
    logic [31:0] cmd_dataB, rsp_dataB, aip_dataInB, aip_dataOutB;
    logic        aip_wrEnB, aip_rdEnB, aip_startB, aip_int_nB;

    always #5 clk = ~clk;

    aip_host_master #(.DATAWIDTH(32), .ADDRWIDTH(5), .READ_LATENCY(LAT_A), .TIMEOUT_CYCLES(TO_A)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .aip_configAX_o(aip_configAX), .aip_dataIn_o(aip_dataIn), .aip_wrEn_o(aip_wrEn),
        .aip_rdEn_o(aip_rdEn), .aip_start_o(aip_start), .aip_dataOut_i(aip_dataOut),
        .aip_int_n_i(aip_int_n)
    );

    aip_host_master #(.DATAWIDTH(32), .ADDRWIDTH(5), .READ_LATENCY(1), .TIMEOUT_CYCLES(TO_A)) u_dut_lat1 (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_validB), .cmd_ready_o(cmd_readyB), .cmd_op_i(cmd_opB),
        .cmd_addr_i(cmd_addrB), .cmd_data_i(cmd_dataB),
        .rsp_valid_o(rsp_validB), .rsp_ready_i(rsp_readyB), .rsp_data_o(rsp_dataB), .rsp_err_o(rsp_errB),
        .aip_configAX_o(aip_configAXB), .aip_dataIn_o(aip_dataInB), .aip_wrEn_o(aip_wrEnB),
        .aip_rdEn_o(aip_rdEnB), .aip_start_o(aip_startB), .aip_dataOut_i(aip_dataOutB),
        .aip_int_n_i(aip_int_nB)
    );

    // Core model: read data is valid only in the cycle exactly LAT after the rdEn cycle.
    logic [31:0] readValue, readValueB;
    logic [3:0]  rdHist;
    logic        rdHistB;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdHist  <= '0;
            rdHistB <= 1'b0;
        end else begin
            rdHist  <= {rdHist[2:0], aip_rdEn};
            rdHistB <= aip_rdEnB;
        end
    end
    assign aip_dataOut  = rdHist[LAT_A-1] ? readValue  : ~readValue;
    assign aip_dataOutB = rdHistB         ? readValueB : ~readValueB;

    // Bus monitor for the main instance.
    int          wrCount = 0, rdCount = 0, startCount = 0;
    logic [4:0]  wrAddr, rdAddr;
    logic [31:0] wrData;
    always @(negedge clk) begin
        if (rst_n) begin
            if (aip_wrEn) begin wrCount++; wrAddr = aip_configAX; wrData = aip_dataIn; end
            if (aip_rdEn) begin rdCount++; rdAddr = aip_configAX; end
            if (aip_start) startCount++;
            checks++;
            if ((int'(aip_wrEn) + int'(aip_rdEn) + int'(aip_start)) > 1) begin
                errors++;
                $display("[TB] FAIL strobe_onehot: wr=%b rd=%b start=%b, at most one allowed", aip_wrEn, aip_rdEn, aip_start);
            end
        end
    end

    function automatic int expCycles(input logic [1:0] op, input int intAt);
        if (op == 2'd1) return LAT_A + 2;
        if (op != 2'd3) return 2;
        if (intAt < 0) return 2;
        if (TO_EN && (intAt == 0 || intAt > TO_A)) return TO_A + 1;
        return intAt + 1;
    endfunction

    function automatic logic expErr(input logic [1:0] op, input int intAt);
        return (op == 2'd3) && TO_EN && (intAt == 0 || intAt > TO_A);
    endfunction

    // Drives one command with rsp_ready high; intAt: 0 never interrupt, -1 interrupt already low, n = low from WAIT cycle n.
    task automatic runCmd(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] data, input int intAt,
                          output logic [31:0] rData, output logic rErr, output int cycles,
                          output int dWr, output int dRd, output int dSt);
        int wr0, rd0, st0, n;
        bit seen;
        wr0 = wrCount; rd0 = rdCount; st0 = startCount;
        rsp_ready = 1'b1;
        if (intAt < 0) aip_int_n = 1'b0;
        cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("[TB] FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
        @(posedge clk); #1 cmd_valid = 1'b0;
        cycles = 0; seen = 0; rData = 'x; rErr = 1'bx;
        while (!seen && cycles < 300) begin
            @(negedge clk); cycles++;
            if (rsp_valid) begin
                seen = 1; rData = rsp_data; rErr = rsp_err;
            end else if (cycles == intAt) begin
                aip_int_n = 1'b0;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("[TB] FAIL rsp_timeout: rsp_valid=0 after %0d cycles, required a response", cycles);
        end
        @(posedge clk); #1;
        aip_int_n = 1'b1;
        dWr = wrCount - wr0; dRd = rdCount - rd0; dSt = startCount - st0;
    endtask

    task automatic test_reset();
        int validSeen, n;
        #3;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0 ||
            aip_wrEn !== 1'b0 || aip_rdEn !== 1'b0 || aip_start !== 1'b0 ||
            aip_configAX !== 5'h0 || aip_dataIn !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_state: rdy=%b vld=%b data=%h err=%b wr=%b rd=%b st=%b ax=%h din=%h, required 1,0,0,0,0,0,0,0,0",
                     cmd_ready, rsp_valid, rsp_data, rsp_err, aip_wrEn, aip_rdEn, aip_start, aip_configAX, aip_dataIn);
        end
        @(negedge clk); rst_n = 1'b1;
        // Abort a READ while its rdEn strobe is high.
        readValue = 32'h1234_5678;
        cmd_op = 2'd1; cmd_addr = 5'h0A; cmd_data = 32'h0; cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1 cmd_valid = 1'b0;
        checks++;
        if (aip_rdEn !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_pre_rdEn: got %b, required 1", aip_rdEn);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (aip_wrEn !== 1'b0 || aip_rdEn !== 1'b0 || aip_start !== 1'b0 || rsp_valid !== 1'b0 ||
            aip_configAX !== 5'h0 || aip_dataIn !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_abort: wr=%b rd=%b st=%b vld=%b ax=%h din=%h, required all 0",
                     aip_wrEn, aip_rdEn, aip_start, rsp_valid, aip_configAX, aip_dataIn);
        end
        @(negedge clk); rst_n = 1'b1;
        validSeen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) validSeen++;
        end
        checks++;
        if (validSeen != 0) begin
            errors++;
            $display("[TB] FAIL reset_no_resp: %0d cycles with rsp_valid or not ready, required 0", validSeen);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        logic [31:0] d; logic e; int c, w, r, s;
        runCmd(2'd0, 5'h04, 32'hDEAD_BEEF, 0, d, e, c, w, r, s);
        checks++;
        if (d !== 32'h0 || e !== 1'b0 || c != 2 || w != 1 || r != 0 || s != 0) begin
            errors++;
            $display("[TB] FAIL write_rsp: data=%h err=%b cyc=%0d wr=%0d rd=%0d st=%0d, required 0,0,2,1,0,0", d, e, c, w, r, s);
        end
        checks++;
        if (wrAddr !== 5'h04 || wrData !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL write_bus: addr=%h data=%h, required 04 deadbeef", wrAddr, wrData);
        end
    endtask

    task automatic test_read();
        logic [31:0] d; logic e; int c, w, r, s;
        readValue = 32'h0000_1001;
        runCmd(2'd1, 5'h1E, 32'h0, 0, d, e, c, w, r, s);
        checks++;
        if (d !== 32'h0000_1001 || e !== 1'b0 || c != LAT_A + 2 || w != 0 || r != 1 || s != 0 || rdAddr !== 5'h1E) begin
            errors++;
            $display("[TB] FAIL read_lat3: data=%h err=%b cyc=%0d wr=%0d rd=%0d st=%0d addr=%h, required 00001001,0,%0d,0,1,0,1e",
                     d, e, c, w, r, s, rdAddr, LAT_A + 2);
        end
    endtask

    task automatic test_read_lat1();
        int n, c, rdSeen, otherSeen;
        logic [4:0] axAtRd;
        readValueB = 32'h0000_1001;
        rsp_readyB = 1'b1;
        cmd_opB = 2'd1; cmd_addrB = 5'h1E; cmd_dataB = 32'h0; cmd_validB = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_readyB && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1 cmd_validB = 1'b0;
        c = 0; rdSeen = 0; otherSeen = 0; axAtRd = 'x;
        while (c < 50) begin
            @(negedge clk); c++;
            if (aip_rdEnB) begin rdSeen++; axAtRd = aip_configAXB; end
            if (aip_wrEnB || aip_startB) otherSeen++;
            if (rsp_validB) break;
        end
        checks++;
        if (rsp_validB !== 1'b1 || rsp_dataB !== 32'h0000_1001 || rsp_errB !== 1'b0 || c != 3 ||
            rdSeen != 1 || otherSeen != 0 || axAtRd !== 5'h1E) begin
            errors++;
            $display("[TB] FAIL read_lat1: vld=%b data=%h err=%b cyc=%0d rd=%0d other=%0d addr=%h, required 1,00001001,0,3,1,0,1e",
                     rsp_validB, rsp_dataB, rsp_errB, c, rdSeen, otherSeen, axAtRd);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_wait();
        logic [31:0] d; logic e; int c, w, r, s;
        int intCases [3] = '{20, -1, 5};
        runCmd(2'd2, 5'h00, 32'h0, 0, d, e, c, w, r, s);
        checks++;
        if (d !== 32'h0 || e !== 1'b0 || c != 2 || w != 0 || r != 0 || s != 1) begin
            errors++;
            $display("[TB] FAIL start_rsp: data=%h err=%b cyc=%0d wr=%0d rd=%0d st=%0d, required 0,0,2,0,0,1", d, e, c, w, r, s);
        end
        foreach (intCases[k]) begin
            runCmd(2'd3, 5'h00, 32'h0, intCases[k], d, e, c, w, r, s);
            checks++;
            if (d !== 32'h0 || e !== expErr(2'd3, intCases[k]) || c != expCycles(2'd3, intCases[k]) || (w + r + s) != 0) begin
                errors++;
                $display("[TB] FAIL wait_int%0d: data=%h err=%b cyc=%0d strobes=%0d, required 0,%b,%0d,0",
                         intCases[k], d, e, c, w + r + s, expErr(2'd3, intCases[k]), expCycles(2'd3, intCases[k]));
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d; logic e; int c, w, r, s;
        int intCases [4] = '{16, 17, 60, 0};
        foreach (intCases[k]) begin
            if (intCases[k] == 0 && !TO_EN) continue;
            runCmd(2'd3, 5'h00, 32'h0, intCases[k], d, e, c, w, r, s);
            checks++;
            if (d !== 32'h0 || e !== expErr(2'd3, intCases[k]) || c != expCycles(2'd3, intCases[k])) begin
                errors++;
                $display("[TB] FAIL timeout_int%0d: data=%h err=%b cyc=%0d, required 0,%b,%0d",
                         intCases[k], d, e, c, expErr(2'd3, intCases[k]), expCycles(2'd3, intCases[k]));
            end
        end
    endtask

    task automatic test_backpressure();
        int n, wr0, rd0, bad;
        logic [4:0] a;
        readValue = $urandom;
        a = 5'($urandom);
        wr0 = wrCount; rd0 = rdCount;
        rsp_ready = 1'b0;
        cmd_op = 2'd1; cmd_addr = a; cmd_data = 32'h0; cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1 cmd_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_rsp: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
        end
        cmd_op = 2'd0; cmd_data = $urandom; cmd_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== readValue || cmd_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL bp_hold: %0d unstable cycles, last data=%h required %h", bad, rsp_data, readValue);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ((wrCount - wr0) != 0 || (rdCount - rd0) != 1 || rdAddr !== a) begin
            errors++;
            $display("[TB] FAIL bp_strobes: wr=%0d rd=%0d addr=%h, required 0,1,%h", wrCount - wr0, rdCount - rd0, rdAddr, a);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_gap: vld=%b rdy=%b, required 0,1", rsp_valid, cmd_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] d, wd, expData; logic e; int c, w, r, s, intAt;
        logic [1:0] op; logic [4:0] a;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a = 5'($urandom);
            wd = $urandom;
            readValue = $urandom;
            intAt = $urandom_range(0, 12);
            if (intAt == 0) intAt = -1;
            if (op != 2'd3) intAt = 0;
            expData = (op == 2'd1) ? readValue : 32'h0;
            runCmd(op, a, wd, intAt, d, e, c, w, r, s);
            checks++;
            if (d !== expData || e !== expErr(op, intAt) || c != expCycles(op, intAt) ||
                w != int'(op == 2'd0) || r != int'(op == 2'd1) || s != int'(op == 2'd2)) begin
                errors++;
                $display("[TB] FAIL rand%0d op%0d: data=%h err=%b cyc=%0d wr=%0d rd=%0d st=%0d, required %h,%b,%0d",
                         i, op, d, e, c, w, r, s, expData, expErr(op, intAt), expCycles(op, intAt));
            end
            checks++;
            if ((op == 2'd0 && (wrAddr !== a || wrData !== wd)) || (op == 2'd1 && rdAddr !== a)) begin
                errors++;
                $display("[TB] FAIL rand%0d_bus: wrAddr=%h wrData=%h rdAddr=%h, required addr %h data %h",
                         i, wrAddr, wrData, rdAddr, a, wd);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_data = '0; rsp_ready = 1'b1; aip_int_n = 1'b1;
        cmd_validB = 1'b0; cmd_opB = 2'd0; cmd_addrB = '0; cmd_dataB = '0; rsp_readyB = 1'b1; aip_int_nB = 1'b1;
        readValue = '0; readValueB = '0;
        test_reset();
        test_write();
        test_read();
        test_read_lat1();
        test_start_wait();
        test_timeout();
        test_backpressure();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
